// File: rtl/enemy_hit_ctl_if.sv
// Missile/formation inputs and hit/score outputs exchanged between
// the timing and missile stages and the enemy hit controller.
interface enemy_hit_ctl_if #(
  parameter int unsigned N = 8
);
  logic          vblnk_in;
  logic [10:0]   xpos_missile;
  logic [10:0]   ypos_missile;
  logic          on_missle;
  logic [10:0]   formation_x;
  logic [10:0]   formation_y;
  logic [N-1:0]  alive_mask;
  logic          missile_hit;
  logic [7:0]    hit_index;
  logic [15:0]   score_bcd;
  logic          wave_clear;
  logic          busy;

  modport master (
    output vblnk_in, xpos_missile, ypos_missile, on_missle, formation_x, formation_y,
    input  alive_mask, missile_hit, hit_index, score_bcd, wave_clear, busy
  );

  modport slave (
    input  vblnk_in, xpos_missile, ypos_missile, on_missle, formation_x, formation_y,
    output alive_mask, missile_hit, hit_index, score_bcd, wave_clear, busy
  );
endinterface

// File: rtl/enemy_hit_ctl.sv
// Per-frame missile vs. enemy-formation hit test: one enemy per cycle, at most one kill
// per frame, BCD score, and a timed respawn once the whole formation is destroyed.
module enemy_hit_ctl #(
  parameter int unsigned COLS           = 4,
  parameter int unsigned ROWS           = 2,
  parameter int unsigned EN_W           = 32,
  parameter int unsigned EN_H           = 32,
  parameter int unsigned SPACING_X      = 64,
  parameter int unsigned SPACING_Y      = 48,
  parameter int unsigned RESPAWN_FRAMES = 60
) (
  input  logic             pclk,
  input  logic             rst,
  enemy_hit_ctl_if.slave   bus
);
  localparam int unsigned N    = COLS * ROWS;
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CntW = $clog2(RESPAWN_FRAMES + 1);

  typedef enum logic [1:0] {StIdle, StScan, StHit, StRespWait} state_e;

  state_e            state_q, state_d;
  logic              vblnk_q, vblnk_d;
  logic [10:0]       xm_q, xm_d, ym_q, ym_d, fx_q, fx_d;
  logic              on_q, on_d;
  logic [11:0]       x0_q, x0_d, y0_q, y0_d;
  logic [IdxW-1:0]   idx_q, idx_d, col_q, col_d;
  logic [N-1:0]      alive_q, alive_d;
  logic              missile_hit_q, missile_hit_d;
  logic              wave_clear_q, wave_clear_d;
  logic [7:0]        hit_index_q, hit_index_d;
  logic [15:0]       score_q, score_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  logic              tick;
  logic              in_box;
  logic [11:0]       x1, y1;
  logic [N-1:0]      kill_mask;

  function automatic logic [15:0] bcd_inc(input logic [15:0] s);
    logic [15:0] r;
    logic        carry;
    r     = s;
    carry = 1'b1;
    for (int d = 0; d < 4; d++) begin
      if (carry) begin
        if (r[4*d +: 4] == 4'd9) begin
          r[4*d +: 4] = 4'd0;
        end else begin
          r[4*d +: 4] = r[4*d +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // x0/y0 track the origin of enemy idx incrementally, avoiding a div/mod on idx.
  assign x1        = x0_q + 12'(EN_W - 1);
  assign y1        = y0_q + 12'(EN_H - 1);
  assign in_box    = ({1'b0, xm_q} >= x0_q) && ({1'b0, xm_q} <= x1) &&
                     ({1'b0, ym_q} >= y0_q) && ({1'b0, ym_q} <= y1);
  assign kill_mask = N'(1) << idx_q;
  assign tick      = bus.vblnk_in & ~vblnk_q;

  always_comb begin
    state_d       = state_q;
    vblnk_d       = bus.vblnk_in;
    xm_d          = xm_q;
    ym_d          = ym_q;
    fx_d          = fx_q;
    on_d          = on_q;
    x0_d          = x0_q;
    y0_d          = y0_q;
    idx_d         = idx_q;
    col_d         = col_q;
    alive_d       = alive_q;
    missile_hit_d = 1'b0;
    wave_clear_d  = 1'b0;
    hit_index_d   = hit_index_q;
    score_d       = score_q;
    cnt_d         = cnt_q;

    unique case (state_q)
      StIdle: begin
        if (tick) begin
          xm_d    = bus.xpos_missile;
          ym_d    = bus.ypos_missile;
          on_d    = bus.on_missle;
          fx_d    = bus.formation_x;
          x0_d    = {1'b0, bus.formation_x};
          y0_d    = {1'b0, bus.formation_y};
          idx_d   = '0;
          col_d   = '0;
          state_d = StScan;
        end
      end
      StScan: begin
        if (!on_q) begin
          state_d = StIdle;
        end else if (alive_q[idx_q] && in_box) begin
          alive_d       = alive_q & ~kill_mask;
          hit_index_d   = 8'(idx_q);
          missile_hit_d = 1'b1;
          wave_clear_d  = ((alive_q & ~kill_mask) == '0);
          state_d       = StHit;
        end else if (idx_q == IdxW'(N - 1)) begin
          state_d = StIdle;
        end else begin
          idx_d = idx_q + 1'b1;
          if (col_q == IdxW'(COLS - 1)) begin
            col_d = '0;
            x0_d  = {1'b0, fx_q};
            y0_d  = y0_q + 12'(SPACING_Y);
          end else begin
            col_d = col_q + 1'b1;
            x0_d  = x0_q + 12'(SPACING_X);
          end
        end
      end
      StHit: begin
        score_d = (score_q == 16'h9999) ? score_q : bcd_inc(score_q);
        if (alive_q == '0) begin
          cnt_d   = CntW'(RESPAWN_FRAMES);
          state_d = StRespWait;
        end else begin
          state_d = StIdle;
        end
      end
      StRespWait: begin
        if (tick) begin
          if (cnt_q == CntW'(1)) begin
            alive_d = '1;
            state_d = StIdle;
          end
          cnt_d = cnt_q - 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q       <= StIdle;
      vblnk_q       <= 1'b0;
      xm_q          <= '0;
      ym_q          <= '0;
      fx_q          <= '0;
      on_q          <= 1'b0;
      x0_q          <= '0;
      y0_q          <= '0;
      idx_q         <= '0;
      col_q         <= '0;
      alive_q       <= '1;
      missile_hit_q <= 1'b0;
      wave_clear_q  <= 1'b0;
      hit_index_q   <= '0;
      score_q       <= '0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      vblnk_q       <= vblnk_d;
      xm_q          <= xm_d;
      ym_q          <= ym_d;
      fx_q          <= fx_d;
      on_q          <= on_d;
      x0_q          <= x0_d;
      y0_q          <= y0_d;
      idx_q         <= idx_d;
      col_q         <= col_d;
      alive_q       <= alive_d;
      missile_hit_q <= missile_hit_d;
      wave_clear_q  <= wave_clear_d;
      hit_index_q   <= hit_index_d;
      score_q       <= score_d;
      cnt_q         <= cnt_d;
    end
  end

  assign bus.alive_mask  = alive_q;
  assign bus.missile_hit = missile_hit_q;
  assign bus.hit_index   = hit_index_q;
  assign bus.score_bcd   = score_q;
  assign bus.wave_clear  = wave_clear_q;
  assign bus.busy        = (state_q != StIdle);
endmodule
